parity_rx: RTL

- Serial receiver that checks the far end of the byte-parity link.
- Takes a framed serial stream: start bit, DATA_W data bits LSB first, one parity bit, stop bit.
- Reassembles the word, recomputes parity as the XOR-reduction of the data, and compares it with the received parity bit.
- Reports the word, a parity-error flag and a framing-error flag, and keeps a saturating error count for link monitoring.

---
 rtl/parity_rx.sv | 115 +++++++++++
 1 files changed

// File: rtl/parity_rx.sv
// Serial parity receiver: start bit, DATA_W data bits LSB first, parity bit, stop bit.
// Reports the word with parity/framing error flags and keeps a saturating error count.
module parity_rx #(
  parameter int unsigned DATA_W = 8,
  parameter bit          ODD    = 1'b0,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_en,
  input  logic              rxd,
  input  logic              cnt_clr,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              par_err,
  output logic              frame_err,
  output logic              busy,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int unsigned       CTR_W    = $clog2(DATA_W + 1);
  localparam logic [CTR_W-1:0]  LAST_BIT = CTR_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t            state, state_next;
  logic [CTR_W-1:0]  bit_cnt, bit_cnt_next;
  logic [DATA_W-1:0] shift, shift_next;
  logic              par_bit, par_bit_next;
  logic [DATA_W-1:0] data_next;
  logic              valid_next, par_err_next, frame_err_next;
  logic [CNT_W-1:0]  err_cnt_next;
  logic              frame_bad;

  // Next-state, datapath and output computation; everything advances only on bit_en.
  always_comb begin
    state_next     = state;
    bit_cnt_next   = bit_cnt;
    shift_next     = shift;
    par_bit_next   = par_bit;
    data_next      = data;
    valid_next     = 1'b0;
    par_err_next   = par_err;
    frame_err_next = frame_err;
    err_cnt_next   = err_cnt;
    frame_bad      = 1'b0;

    if (bit_en) begin
      case (state)
        IDLE: begin
          if (!rxd) begin
            state_next   = DATA;
            bit_cnt_next = '0;
          end
        end
        DATA: begin
          // LSB arrives first, so new bits enter at the MSB and walk down.
          shift_next             = shift >> 1;
          shift_next[DATA_W-1]   = rxd;
          bit_cnt_next           = bit_cnt + CTR_W'(1);
          if (bit_cnt == LAST_BIT) state_next = PARITY;
        end
        PARITY: begin
          par_bit_next = rxd;
          state_next   = STOP;
        end
        STOP: begin
          data_next      = shift;
          par_err_next   = ((^shift) ^ ODD) != par_bit;
          frame_err_next = ~rxd;
          valid_next     = 1'b1;
          frame_bad      = par_err_next | frame_err_next;
          state_next     = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end

    // Clear has priority over a coincident erroring frame.
    if (cnt_clr) begin
      err_cnt_next = '0;
    end else if (frame_bad && (err_cnt != CNT_MAX)) begin
      err_cnt_next = err_cnt + CNT_W'(1);
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      par_bit   <= 1'b0;
      data      <= '0;
      valid     <= 1'b0;
      par_err   <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state     <= state_next;
      bit_cnt   <= bit_cnt_next;
      shift     <= shift_next;
      par_bit   <= par_bit_next;
      data      <= data_next;
      valid     <= valid_next;
      par_err   <= par_err_next;
      frame_err <= frame_err_next;
      busy      <= (state_next != IDLE);
      err_cnt   <= err_cnt_next;
    end
  end

endmodule
